frame_anim_ctrl: RTL and testbench
==================================

Name: frame_anim_ctrl

Overview:
- Per-frame animation controller that generates the scroll offset consumed by the sine-wave scene and the "UW" player logic.
- Runs entirely in the pixel clock domain and detects frame boundaries from the sync generator's vsync output; it does not clock anything on vsync.
- Conditions the raw user switches (speed, direction, pause) and produces x_offset, game_started and a one-cycle frame_tick for downstream stages.

Parameters:
- PERIOD, 400, x_offset modulus (one full scroll cycle, 10 bars x 40 px).
- OFS_W, 10, width of x_offset.
- SPD_W, 4, width of the speed field.
- DEFAULT_SPEED, 4, speed held in reset and during the START state.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  vertical sync from the sync generator, active high, synchronous to clk.
- ui_speed  in  SPD_W  raw speed switches (asynchronous).
- ui_dir  in  1  raw direction switch: 0 = forward, 1 = reverse (asynchronous).
- ui_pause  in  1  raw pause switch (asynchronous).
- x_offset  out  OFS_W  scroll offset, always in the range 0..PERIOD-1.
- game_started  out  1  high once the first frame has elapsed since reset.
- frame_tick  out  1  one-cycle pulse per frame.
- cur_speed  out  SPD_W  speed applied at the most recent update.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high on port reset.
- Reset values:
  - x_offset = 0, game_started = 0, frame_tick = 0, cur_speed = DEFAULT_SPEED.
  - State = START; all synchroniser flops = 0.
- Input synchronisers:
  - ui_speed, ui_dir and ui_pause each pass through a 2-flop synchroniser.
  - vsync passes through 2 flops plus a third history flop.
- Frame edge detection:
  - edge = vs_s2 & ~vs_s3.
  - frame_tick is registered from edge, so it goes high 3 clk edges after the first edge that samples vsync high, and stays high for exactly 1 cycle.
  - vsync held high for many lines produces a single tick.
- Update timing: x_offset, game_started and cur_speed update on the same edge as frame_tick rises. The new values are therefore visible in the cycle where frame_tick = 1.
- Effective speed: spd = (sync speed == 0) ? 1 : sync speed. A zero speed never stalls the scroll.
- Offset arithmetic, using OFS_W+1 bits internally:
  - Forward: t = x + spd; x_next = (t >= PERIOD) ? t - PERIOD : t.
  - Reverse: x_next = (x < spd) ? x + PERIOD - spd : x - spd.
  - No divider or modulo operator is used.
- State machine, evaluated only on edge cycles:
  - START: on edge → RUN, game_started <= 1, x_offset unchanged on this first tick.
  - RUN: on edge, if sync pause = 1 → PAUSE with x unchanged; else x_offset <= x_next.
  - PAUSE: on edge, if sync pause = 0 → RUN with x unchanged on this tick; else stay in PAUSE.
  - game_started stays 1 until reset.
- Input sampling: direction and speed are sampled only at the edge cycle. Changes between ticks have no effect until the next tick.
- Reset mid-frame: outputs clear immediately (asynchronously). The first tick after reset release only performs START → RUN.

Optional Feature:
- Macro: FRAME_ANIM_RAMP_EN.
- Defined:
  - cur_speed moves toward the target spd by ±1 per RUN tick, and the offset step uses cur_speed.
  - A direction reversal is deferred until cur_speed == 1: the ramp goes down first, the direction flips, then the ramp goes back up.
  - PAUSE keeps cur_speed.
- Undefined: cur_speed = spd on every RUN tick, and direction applies immediately.

Decomposition:
- Package anim_pkg holds:
  - PERIOD, OFS_W, SPD_W, DEFAULT_SPEED.
  - State encoding ST_START = 0, ST_RUN = 1, ST_PAUSE = 2 (2-bit).
- Sub-module sync_2ff (parameterised width) is used for the switch bus and for vsync.
- The edge detector, FSM and accumulator stay in the top module.

Test Plan:
- Reset release, speed = 4, dir = 0, 3 vsync pulses:
  - Tick 1: game_started = 1, x_offset = 0.
  - Ticks 2 and 3: x_offset = 4, then 8.
  - Each frame_tick lasts exactly 1 cycle, 3 edges after vsync rises.
- Forward wrap: x_offset = 396, speed = 7, one tick → x_offset = 3.
- Reverse wrap: x_offset = 2, dir = 1, speed = 5 → x_offset = 397. Speed = 0 → step of 1 (397 → 396).
- Pause: pause = 1 at a tick → x_offset frozen over 5 ticks. Pause = 0 → next tick unchanged, following tick advances by spd.
- vsync held high for 1000 cycles → exactly one frame_tick. Reset asserted mid-RUN → x_offset = 0 and game_started = 0 in the same cycle, without waiting for a clk edge.
- FRAME_ANIM_RAMP_EN, ramp and reversal:
  - cur_speed 1, target 4: ticks give 2, 3, 4.
  - Then set dir = 1: cur_speed steps 3, 2, 1 with x still increasing, then the offset decreases.

Source files
------------

// File: rtl/frame_anim_ctrl_pkg.sv
// Shared constants, FSM encoding and offset-step helper for frame_anim_ctrl.
package anim_pkg;

  localparam int unsigned PERIOD        = 400;  // 10 bars x 40 px
  localparam int unsigned OFS_W         = 10;
  localparam int unsigned SPD_W         = 4;
  localparam int unsigned DEFAULT_SPEED = 4;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } anim_state_e;

  // One scroll step modulo PERIOD; assumes x < PERIOD and spd <= PERIOD, so a
  // single conditional add/subtract replaces a modulo operator.
  function automatic logic [OFS_W-1:0] step_offset(input logic [OFS_W-1:0] x,
                                                   input logic [SPD_W-1:0] spd,
                                                   input logic             dir);
    logic [OFS_W:0] w_x;
    logic [OFS_W:0] w_s;
    logic [OFS_W:0] w_p;
    logic [OFS_W:0] w_t;
    w_x = {1'b0, x};
    w_s = (OFS_W+1)'(spd);
    w_p = (OFS_W+1)'(PERIOD);
    if (!dir) begin
      w_t = w_x + w_s;
      if (w_t >= w_p) w_t = w_t - w_p;
    end else if (w_x < w_s) begin
      w_t = w_x + w_p - w_s;
    end else begin
      w_t = w_x - w_s;
    end
    return w_t[OFS_W-1:0];
  endfunction

endpackage

// File: rtl/frame_anim_ctrl_sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Metastability-settling chain; both stages clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/frame_anim_ctrl.sv
// Per-frame scroll controller: detects vsync rising edges in the pixel clock
// domain and advances x_offset once per frame from conditioned user switches.
// Optional speed ramp with deferred reversal: define FRAME_ANIM_RAMP_EN.
module frame_anim_ctrl
  import anim_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic [SPD_W-1:0] ui_speed,
  input  logic             ui_dir,
  input  logic             ui_pause,
  output logic [OFS_W-1:0] x_offset,
  output logic             game_started,
  output logic             frame_tick,
  output logic [SPD_W-1:0] cur_speed
);

  localparam logic [SPD_W-1:0] SPD_ONE     = SPD_W'(1);
  localparam logic [SPD_W-1:0] SPD_DEFAULT = SPD_W'(DEFAULT_SPEED);

  logic [SPD_W+1:0] w_sw_sync;
  logic [SPD_W-1:0] w_spd_sync;
  logic             w_dir_sync;
  logic             w_pause_sync;
  logic [SPD_W-1:0] w_spd_eff;
  logic             w_vs_s2;
  logic             r_vs_s3;
  logic             w_edge;
  logic             r_frame_tick;

  anim_state_e      r_state;
  anim_state_e      w_state_next;
  logic [OFS_W-1:0] r_x;
  logic [OFS_W-1:0] w_x_next;
  logic             r_started;
  logic             w_started_next;
  logic [SPD_W-1:0] r_cur;
  logic [SPD_W-1:0] w_cur_next;
`ifdef FRAME_ANIM_RAMP_EN
  logic             r_dir;
  logic             w_dir_next;
`endif

  sync_2ff #(
    .WIDTH(SPD_W + 2)
  ) u_sync_sw (
    .clk  (clk),
    .reset(reset),
    .i_d  ({ui_pause, ui_dir, ui_speed}),
    .o_q  (w_sw_sync)
  );

  sync_2ff #(
    .WIDTH(1)
  ) u_sync_vs (
    .clk  (clk),
    .reset(reset),
    .i_d  (vsync),
    .o_q  (w_vs_s2)
  );

  assign w_spd_sync   = w_sw_sync[SPD_W-1:0];
  assign w_dir_sync   = w_sw_sync[SPD_W];
  assign w_pause_sync = w_sw_sync[SPD_W+1];
  // Zero speed would stall the scroll, so it is promoted to 1.
  assign w_spd_eff    = (w_spd_sync == '0) ? SPD_ONE : w_spd_sync;
  assign w_edge       = w_vs_s2 & ~r_vs_s3;

  // vsync history flop and registered frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_s3      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_s3      <= w_vs_s2;
      r_frame_tick <= w_edge;
    end
  end

  // FSM state and per-frame accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_START;
      r_x       <= '0;
      r_started <= 1'b0;
      r_cur     <= SPD_DEFAULT;
`ifdef FRAME_ANIM_RAMP_EN
      r_dir     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_x       <= w_x_next;
      r_started <= w_started_next;
      r_cur     <= w_cur_next;
`ifdef FRAME_ANIM_RAMP_EN
      r_dir     <= w_dir_next;
`endif
    end
  end

  // Next-state logic; everything holds except on a vsync edge cycle.
  always_comb begin
    w_state_next   = r_state;
    w_x_next       = r_x;
    w_started_next = r_started;
    w_cur_next     = r_cur;
`ifdef FRAME_ANIM_RAMP_EN
    w_dir_next     = r_dir;
`endif
    if (w_edge) begin
      case (r_state)
        ST_START: begin
          w_state_next   = ST_RUN;
          w_started_next = 1'b1;
        end
        ST_RUN: begin
          if (w_pause_sync) begin
            w_state_next = ST_PAUSE;
          end else begin
`ifdef FRAME_ANIM_RAMP_EN
            // A pending reversal first ramps down to 1, then flips and climbs.
            if (w_dir_sync != r_dir) begin
              if (r_cur > SPD_ONE) begin
                w_cur_next = r_cur - SPD_ONE;
              end else begin
                w_dir_next = w_dir_sync;
                w_cur_next = (w_spd_eff > r_cur) ? r_cur + SPD_ONE : r_cur;
              end
            end else if (w_spd_eff > r_cur) begin
              w_cur_next = r_cur + SPD_ONE;
            end else if (w_spd_eff < r_cur) begin
              w_cur_next = r_cur - SPD_ONE;
            end
            w_x_next = step_offset(r_x, w_cur_next, w_dir_next);
`else
            w_cur_next = w_spd_eff;
            w_x_next   = step_offset(r_x, w_spd_eff, w_dir_sync);
`endif
          end
        end
        ST_PAUSE: begin
          if (!w_pause_sync) w_state_next = ST_RUN;
        end
        default: w_state_next = ST_START;
      endcase
    end
  end

  assign x_offset     = r_x;
  assign game_started = r_started;
  assign frame_tick   = r_frame_tick;
  assign cur_speed    = r_cur;

endmodule

// File: tb/tb_frame_anim_ctrl.sv
// Self-checking bench for frame_anim_ctrl (default build, ramp disabled).
module tb_frame_anim_ctrl;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic [3:0] ui_speed;
  logic       ui_dir;
  logic       ui_pause;
  logic [9:0] x_offset;
  logic       game_started;
  logic       frame_tick;
  logic [3:0] cur_speed;

  frame_anim_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .ui_speed    (ui_speed),
    .ui_dir      (ui_dir),
    .ui_pause    (ui_pause),
    .x_offset    (x_offset),
    .game_started(game_started),
    .frame_tick  (frame_tick),
    .cur_speed   (cur_speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] spd;
    logic       dir;
    logic       pause;
    int         x;
    logic       started;
    int         cur;
  } vec_t;

  typedef struct {
    int   x;
    logic started;
    int   cur;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_tick = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int spd, input bit dir, input bit pause, input int x,
                              input bit started, input int cur);
    vec_t v;
    v.spd = spd[3:0]; v.dir = dir; v.pause = pause;
    v.x = x; v.started = started; v.cur = cur;
    return v;
  endfunction

  // Scoreboard consumer: every tick pops one expected record; ticks must be 1 cycle wide.
  always @(negedge clk) begin
    if (!reset && frame_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("x_offset", int'(x_offset), e.x);
        check("game_started", int'(game_started), int'(e.started));
        check("cur_speed", int'(cur_speed), e.cur);
      end
      if (prev_tick) check("tick_width", 2, 1);
    end
    prev_tick = reset ? 1'b0 : frame_tick;
  end

  // Drive switches, raise vsync for `hold` cycles, and check tick latency and count.
  task automatic frame(input vec_t v, input int hold);
    exp_t e;
    int   first;
    int   cnt;
    @(negedge clk);
    ui_speed = v.spd; ui_dir = v.dir; ui_pause = v.pause;
    repeat (4) @(negedge clk);
    e.x = v.x; e.started = v.started; e.cur = v.cur;
    sb.push_back(e);
    vsync = 1'b1;
    first = -1; cnt = 0;
    for (int i = 1; i <= hold + 6; i++) begin
      @(posedge clk);
      #1;
      if (frame_tick) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == hold) begin
        @(negedge clk);
        vsync = 1'b0;
      end
    end
    check("tick_latency", first, 3);
    check("tick_count", cnt, 1);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; ui_speed = 4'd4; ui_dir = 1'b0; ui_pause = 1'b0;
    #23;
    check("rst_x", int'(x_offset), 0);
    check("rst_started", int'(game_started), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_cur", int'(cur_speed), 4);
    @(negedge clk);
    reset = 1'b0;

    // First tick only starts the game; offset then advances by the speed.
    vecs.push_back(mk(4, 0, 0, 0, 1, 4));
    vecs.push_back(mk(4, 0, 0, 4, 1, 4));
    vecs.push_back(mk(4, 0, 0, 8, 1, 4));
    for (int k = 1; k <= 25; k++) vecs.push_back(mk(15, 0, 0, 8 + 15 * k, 1, 15));
    vecs.push_back(mk(13, 0, 0, 396, 1, 13));
    vecs.push_back(mk(7, 0, 0, 3, 1, 7));      // forward wrap 396+7-400
    vecs.push_back(mk(1, 1, 0, 2, 1, 1));
    vecs.push_back(mk(5, 1, 0, 397, 1, 5));    // reverse wrap 2+400-5
    vecs.push_back(mk(0, 1, 0, 396, 1, 1));    // zero speed steps by 1
    for (int k = 0; k < 5; k++) vecs.push_back(mk(3, 0, 1, 396, 1, 1));
    vecs.push_back(mk(3, 0, 0, 396, 1, 1));    // leaving pause does not move
    vecs.push_back(mk(3, 0, 0, 399, 1, 3));
    vecs.push_back(mk(3, 0, 0, 2, 1, 3));

    foreach (vecs[i]) frame(vecs[i], 3);

    // Long vsync: one tick only.
    frame(mk(3, 0, 0, 5, 1, 3), 1000);

    // Asynchronous reset mid-RUN clears outputs before the next clock edge.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_x", int'(x_offset), 0);
    check("async_rst_started", int'(game_started), 0);
    check("async_rst_cur", int'(cur_speed), 4);
    @(negedge clk);
    reset = 1'b0;
    frame(mk(6, 0, 0, 0, 1, 4), 3);
    frame(mk(6, 0, 0, 6, 1, 6), 3);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
